serial_adder: RTL and testbench
===============================

# serial_adder

Parametrised bit-serial adder/subtractor built around a single full-adder cell and a carry flop. It is the sequential successor to the team's combinational half-adder cell and is used where area matters more than latency. The block accepts a WIDTH-bit operand pair on a start pulse and processes one bit per clock, LSB first. It reports the sum, carry-out and signed overflow with a one-cycle done pulse.

## Interface
- WIDTH, default 8: operand and result width in bits; legal range 1..64.
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request a new operation; sampled only in IDLE.
- a  input  WIDTH  operand A; captured on the accepted start.
- b  input  WIDTH  operand B; captured on the accepted start.
- cin  input  1  carry-in for add mode; ignored when sub=1.
- sub  input  1  0: a+b+cin; 1: a-b, computed as a+~b+1.
- busy  output  1  high while bits are being processed (RUN).
- done  output  1  one-cycle pulse; sum, cout and ovf are valid from this cycle onward.
- sum  output  WIDTH  result; held until the next completion.
- cout  output  1  carry-out; in sub mode 1 means no borrow.
- ovf  output  1  signed overflow, equal to carry into MSB XOR carry out of MSB.

## Operation
- One clock domain. Reset is synchronous and active-high (clk, rst).
- FSM states are IDLE, RUN and DONE.
  - IDLE -> RUN when start=1. On that edge: a_sh<=a; b_sh<=sub?~b:b; c<=sub?1:cin; bit count<=0.
  - RUN: each edge computes s=a_sh[0]^b_sh[0]^c.
    - s is shifted into the MSB of the internal result shift register.
    - c<=majority(a_sh[0],b_sh[0],c).
    - a_sh and b_sh shift right; count increments.
  - RUN -> DONE on the edge that processes bit WIDTH-1. On that same edge: sum<=completed shift register; cout<=final carry; ovf<=carry into bit WIDTH-1 XOR final carry.
  - DONE -> IDLE unconditionally on the next edge.
- The counter is $clog2(WIDTH+1) bits wide. WIDTH=1 is legal: RUN lasts exactly one cycle.
- start is ignored in RUN and DONE. No queueing.
- Operand inputs a, b, cin and sub may change freely after the accepted start without affecting the result.
- sum, cout and ovf change only on the completion edge. They are stable at all other times, including during the next RUN.

## Timing
- Reset values: state=IDLE, busy=0, done=0, sum=0, cout=0, ovf=0. Internal shift registers, carry and counter are cleared.
- Reset asserted in any state aborts the operation on that edge. No done is produced, and outputs take their reset values.
- Label the start-accept edge E0. Bits 0..WIDTH-1 are processed on edges E1..E_WIDTH.
- busy is high in the cycles after E0 up to and including the cycle ending at E_WIDTH, i.e. WIDTH cycles.
- done is high for exactly the one cycle after E_WIDTH, so latency is WIDTH cycles from start accept to done.
- Earliest next accepted start is sampled on edge E_WIDTH+2, giving a throughput of one operation per WIDTH+2 cycles.
- start held continuously high yields back-to-back operations at that rate, each producing one done pulse.
- rst and start asserted on the same edge: rst wins and the FSM stays in IDLE.

## Test plan
- Reset: drive rst for 2 cycles with start=1 and random operands -> busy=0, done=0, sum=0, cout=0, ovf=0 throughout; no operation starts.
- Add with signed overflow (WIDTH=8): a=8'h5A, b=8'h3C, cin=0, sub=0 -> done exactly 8 cycles after the accept edge; sum=8'h96, cout=0, ovf=1; busy high for 8 cycles.
- Carry wrap: a=8'hFF, b=8'h01, cin=0 -> sum=8'h00, cout=1, ovf=0. Then a=8'hFF, b=8'h00, cin=1 -> sum=8'h00, cout=1, ovf=0.
- Subtract: a=8'h10, b=8'h20, sub=1, cin=1 -> sum=8'hF0, cout=0, ovf=0 (cin ignored). Then a=8'h80, b=8'h01, sub=1 -> sum=8'h7F, cout=1, ovf=1.
- Operand independence and re-start: start a=8'h01, b=8'h02; then change a/b to 8'hFF and pulse start during RUN -> a single done with sum=8'h03. Held start -> done pulses spaced 10 cycles apart.
- Abort and small width:
  - Assert rst 4 cycles into RUN -> no done, outputs 0; a subsequent 8'h22+8'h11 gives sum=8'h33.
  - WIDTH=1 instance: exhaust all 8 combinations of {a,b,cin} with sub=0 -> sum/cout match the full-adder truth table, with done 1 cycle after accept.

Source files
------------

// File: rtl/serial_adder_if.sv
// Operand/result bundle for the bit-serial adder.
// The requester drives the operands; the adder returns status and result.
interface serial_adder_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  modport master (
    output start, a, b, cin, sub,
    input  busy, done, sum, cout, ovf
  );

  modport slave (
    input  start, a, b, cin, sub,
    output busy, done, sum, cout, ovf
  );
endinterface

// File: rtl/serial_adder.sv
// Bit-serial adder/subtractor: one full-adder cell plus a carry flop,
// processing one operand bit per clock, LSB first.
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic           clk,
  input  logic           rst,
  serial_adder_if.slave  bus
);
  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_res;
  logic             r_c;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_sum;
  logic             r_cout;
  logic             r_ovf;

  logic             w_s;
  logic             w_cn;
  logic             w_last;
  logic [WIDTH-1:0] w_res_nx;

  assign w_s      = r_a[0] ^ r_b[0] ^ r_c;
  assign w_cn     = (r_a[0] & r_b[0])
                  | (r_a[0] & r_c)
                  | (r_b[0] & r_c);
  assign w_last   = (r_cnt == CW'(WIDTH - 1));
  // new bit enters at the MSB; after WIDTH shifts bit 0 sits at the LSB
  assign w_res_nx = WIDTH'({w_s, r_res} >> 1);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_res   <= '0;
      r_c     <= 1'b0;
      r_cnt   <= '0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (bus.start) begin
            r_a     <= bus.a;
            r_b     <= bus.sub ? ~bus.b : bus.b;
            r_c     <= bus.sub ? 1'b1 : bus.cin;
            r_cnt   <= '0;
            r_state <= RUN;
          end
        end
        RUN: begin
          r_res <= w_res_nx;
          r_c   <= w_cn;
          r_a   <= r_a >> 1;
          r_b   <= r_b >> 1;
          r_cnt <= r_cnt + CW'(1);
          if (w_last) begin
            r_sum   <= w_res_nx;
            r_cout  <= w_cn;
            r_ovf   <= r_c ^ w_cn;
            r_state <= DONE;
          end
        end
        DONE:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.busy = (r_state == RUN);
  assign bus.done = (r_state == DONE);
  assign bus.sum  = r_sum;
  assign bus.cout = r_cout;
  assign bus.ovf  = r_ovf;
endmodule

// File: tb/tb_serial_adder.sv
// Directed scoreboard bench for serial_adder at WIDTH=8 and WIDTH=1.
// Expected results are queued at stimulus time and popped on done.
module tb_serial_adder;
  typedef struct packed {
    logic [7:0] sum;
    logic       cout;
    logic       ovf;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   n_assert = 0;
  int   n_fail   = 0;
  exp_t q8[$];
  exp_t q1[$];

  always #5 clk = ~clk;

  serial_adder_if #(.WIDTH(8)) bus8 ();
  serial_adder_if #(.WIDTH(1)) bus1 ();

  serial_adder #(.WIDTH(8)) dut8 (
    .clk (clk),
    .rst (rst),
    .bus (bus8)
  );

  serial_adder #(.WIDTH(1)) dut1 (
    .clk (clk),
    .rst (rst),
    .bus (bus1)
  );

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model8(input logic [7:0] a,
                                  input logic [7:0] b,
                                  input logic cin,
                                  input logic sub);
    exp_t       e;
    logic [7:0] bb;
    logic [8:0] full;
    bb    = sub ? ~b : b;
    full  = {1'b0, a} + {1'b0, bb} + {8'd0, (sub ? 1'b1 : cin)};
    e.sum  = full[7:0];
    e.cout = full[8];
    e.ovf  = (a[7] == bb[7]) && (full[7] != a[7]);
    return e;
  endfunction

  task automatic pop_cmp8(input string tag);
    exp_t e;
    if (q8.size() == 0) begin
      chk({tag, "_sb_empty"}, 64'd0, 64'd1);
    end else begin
      e = q8.pop_front();
      chk({tag, "_sum"},  bus8.sum,  e.sum);
      chk({tag, "_cout"}, bus8.cout, e.cout);
      chk({tag, "_ovf"},  bus8.ovf,  e.ovf);
    end
  endtask

  // Called at a negedge inside RUN; lat/bn are cycles already elapsed.
  task automatic wait_done8(input string tag, input int lat0, input int bn0);
    int         lat;
    int         bn;
    logic [7:0] s0;
    lat = lat0;
    bn  = bn0;
    s0  = bus8.sum;
    while (!bus8.done && lat < 40) begin
      if (bus8.busy) bn++;
      @(negedge clk);
      lat++;
      if (!bus8.done) chk({tag, "_hold"}, bus8.sum, s0);
    end
    chk({tag, "_done"}, bus8.done, 1'b1);
    chk({tag, "_lat"}, lat, 8);
    chk({tag, "_busy_cycles"}, bn, 8);
    pop_cmp8(tag);
    @(negedge clk);
    chk({tag, "_pulse"}, bus8.done, 1'b0);
  endtask

  task automatic run8(input string tag,
                      input logic [7:0] a,
                      input logic [7:0] b,
                      input logic cin,
                      input logic sub);
    @(negedge clk);
    bus8.a     = a;
    bus8.b     = b;
    bus8.cin   = cin;
    bus8.sub   = sub;
    bus8.start = 1'b1;
    q8.push_back(model8(a, b, cin, sub));
    @(negedge clk);
    bus8.start = 1'b0;
    wait_done8(tag, 0, 0);
  endtask

  task automatic run1(input logic a, input logic b, input logic cin);
    exp_t e;
    int   lat;
    e.sum  = {7'd0, a ^ b ^ cin};
    e.cout = (a & b) | (a & cin) | (b & cin);
    e.ovf  = cin ^ e.cout;
    @(negedge clk);
    bus1.a     = a;
    bus1.b     = b;
    bus1.cin   = cin;
    bus1.sub   = 1'b0;
    bus1.start = 1'b1;
    q1.push_back(e);
    @(negedge clk);
    bus1.start = 1'b0;
    chk("w1_busy", bus1.busy, 1'b1);
    lat = 0;
    while (!bus1.done && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    chk("w1_done", bus1.done, 1'b1);
    chk("w1_lat", lat, 1);
    e = q1.pop_front();
    chk("w1_sum",  bus1.sum,  e.sum[0]);
    chk("w1_cout", bus1.cout, e.cout);
    chk("w1_ovf",  bus1.ovf,  e.ovf);
    @(negedge clk);
    chk("w1_pulse", bus1.done, 1'b0);
  endtask

  initial begin
    int dn;
    int gap;
    int bn;

    rst        = 1'b1;
    bus8.start = 1'b1;
    bus8.a     = 8'($urandom);
    bus8.b     = 8'($urandom);
    bus8.cin   = 1'b1;
    bus8.sub   = 1'b0;
    bus1.start = 1'b1;
    bus1.a     = 1'b1;
    bus1.b     = 1'b1;
    bus1.cin   = 1'b1;
    bus1.sub   = 1'b0;

    // reset with start held high
    repeat (2) begin
      @(negedge clk);
      chk("rst_busy", bus8.busy, 1'b0);
      chk("rst_done", bus8.done, 1'b0);
      chk("rst_sum",  bus8.sum,  8'h00);
      chk("rst_cout", bus8.cout, 1'b0);
      chk("rst_ovf",  bus8.ovf,  1'b0);
      chk("rst_w1_busy", bus1.busy, 1'b0);
      bus8.a = 8'($urandom);
      bus8.b = 8'($urandom);
    end
    rst        = 1'b0;
    bus8.start = 1'b0;
    bus1.start = 1'b0;
    @(negedge clk);
    chk("post_rst_idle", bus8.busy, 1'b0);

    run8("add_ovf",  8'h5A, 8'h3C, 1'b0, 1'b0);
    run8("wrap_b1",  8'hFF, 8'h01, 1'b0, 1'b0);
    run8("wrap_cin", 8'hFF, 8'h00, 1'b1, 1'b0);
    run8("sub_neg",  8'h10, 8'h20, 1'b1, 1'b1);
    run8("sub_ovf",  8'h80, 8'h01, 1'b0, 1'b1);

    // operand changes and a stray start during RUN
    @(negedge clk);
    bus8.a     = 8'h01;
    bus8.b     = 8'h02;
    bus8.cin   = 1'b0;
    bus8.sub   = 1'b0;
    bus8.start = 1'b1;
    q8.push_back(model8(8'h01, 8'h02, 1'b0, 1'b0));
    @(negedge clk);
    bus8.start = 1'b0;
    bus8.a     = 8'hFF;
    bus8.b     = 8'hFF;
    bn = bus8.busy ? 1 : 0;
    @(negedge clk);
    bn += bus8.busy ? 1 : 0;
    @(negedge clk);
    bn += bus8.busy ? 1 : 0;
    bus8.start = 1'b1;
    @(negedge clk);
    bus8.start = 1'b0;
    wait_done8("restart", 3, bn);
    dn = 0;
    repeat (12) begin
      @(negedge clk);
      if (bus8.done) dn++;
    end
    chk("restart_single", dn, 0);

    // held start: back-to-back operations
    @(negedge clk);
    bus8.a     = 8'h33;
    bus8.b     = 8'h44;
    bus8.start = 1'b1;
    q8.push_back(model8(8'h33, 8'h44, 1'b0, 1'b0));
    q8.push_back(model8(8'h33, 8'h44, 1'b0, 1'b0));
    @(negedge clk);
    wait_done8("held1", 0, 0);
    gap = 1;
    while (!bus8.done && gap < 40) begin
      @(negedge clk);
      gap++;
    end
    bus8.start = 1'b0;
    chk("held2_done", bus8.done, 1'b1);
    chk("held_gap", gap, 10);
    pop_cmp8("held2");
    @(negedge clk);
    chk("held2_pulse", bus8.done, 1'b0);

    // abort four cycles into RUN
    @(negedge clk);
    bus8.a     = 8'h77;
    bus8.b     = 8'h05;
    bus8.start = 1'b1;
    @(negedge clk);
    bus8.start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_busy", bus8.busy, 1'b0);
    chk("abort_done", bus8.done, 1'b0);
    chk("abort_sum",  bus8.sum,  8'h00);
    chk("abort_cout", bus8.cout, 1'b0);
    chk("abort_ovf",  bus8.ovf,  1'b0);
    dn = 0;
    repeat (12) begin
      @(negedge clk);
      if (bus8.done) dn++;
    end
    chk("abort_no_done", dn, 0);
    run8("after_abort", 8'h22, 8'h11, 1'b0, 1'b0);

    // WIDTH=1 full-adder truth table
    for (int i = 0; i < 8; i++) begin
      logic [2:0] v;
      v = 3'(i);
      run1(v[2], v[1], v[0]);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end
endmodule
